// File: rtl/ddr5_rd_pkg.sv
// Shared constants for the DDR5 read-path gap tracker: mode codes, FSM encodings
// and the field layout of a queued gap entry {first, ovf, gap}.
package ddr5_rd_pkg;

  localparam int GAP_MODE_RISE = 0;
  localparam int GAP_MODE_FALL = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int ENTRY_GAP_OFS = 0;

  function automatic int entry_ovf_ofs(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int entry_first_ofs(input int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int entry_w(input int cnt_w);
    return cnt_w + 2;
  endfunction

endpackage

// File: rtl/rd_gap_tracker_if.sv
// Bus between the read-gap tracker and the read-path scheduler.
// RD_GAP_STATS_EN adds the gap_min/gap_max statistics signals.
interface rd_gap_tracker_if #(
  parameter int CNT_W = 5,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             rddata_en;
  logic             clear;
  logic             gap_ready;
  logic             gap_valid;
  logic [CNT_W-1:0] gap_count;
  logic             gap_ovf;
  logic             gap_first;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full;
  logic             drop_err;
  logic             cnt_busy;

`ifdef RD_GAP_STATS_EN
  logic [CNT_W-1:0] gap_min;
  logic [CNT_W-1:0] gap_max;

  modport master (
    output rddata_en, clear, gap_ready,
    input  gap_valid, gap_count, gap_ovf, gap_first, fifo_level, fifo_full,
           drop_err, cnt_busy, gap_min, gap_max
  );
  modport slave (
    input  rddata_en, clear, gap_ready,
    output gap_valid, gap_count, gap_ovf, gap_first, fifo_level, fifo_full,
           drop_err, cnt_busy, gap_min, gap_max
  );
`else
  modport master (
    output rddata_en, clear, gap_ready,
    input  gap_valid, gap_count, gap_ovf, gap_first, fifo_level, fifo_full,
           drop_err, cnt_busy
  );
  modport slave (
    input  rddata_en, clear, gap_ready,
    output gap_valid, gap_count, gap_ovf, gap_first, fifo_level, fifo_full,
           drop_err, cnt_busy
  );
`endif

endinterface

// File: rtl/rd_gap_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module rd_gap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop) & ~clear;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rd_gap_tracker.sv
// Read-gap tracker: measures idle distance between rddata_en bursts and queues tagged entries.
// Optional macro RD_GAP_STATS_EN adds running gap_min/gap_max over non-first entries.
//
// state | meaning
// IDLE  | no rise seen since reset/clear
// RUN   | counting the gap to the next rise
module rd_gap_tracker
  import ddr5_rd_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter int DEPTH    = 4,
  parameter int GAP_MODE = GAP_MODE_RISE
) (
  input logic             clk,
  input logic             reset_n,
  rd_gap_tracker_if.slave bus
);

  localparam int EW      = entry_w(CNT_W);
  localparam int OVF_B   = entry_ovf_ofs(CNT_W);
  localparam int FIRST_B = entry_first_ofs(CNT_W);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic             last_en;
  logic             rise;
  logic             fall;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             push_req;
  logic             pop_ok;
  logic             drop;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head;
  logic             fifo_empty;
  logic             fifo_full;

  assign rise     = bus.rddata_en & ~last_en;
  assign fall     = ~bus.rddata_en & last_en;
  assign push_req = rise & ~bus.clear;
  assign pop_ok   = bus.gap_ready & ~fifo_empty;
  assign drop     = push_req & fifo_full & ~pop_ok;

  always_comb begin
    push_entry = '0;
    if (state == ST_IDLE) begin
      push_entry[FIRST_B] = 1'b1;
    end else begin
      push_entry[ENTRY_GAP_OFS +: CNT_W] = cnt;
      push_entry[OVF_B]                  = sat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_en <= 1'b0;
      state   <= ST_IDLE;
      cnt     <= '0;
      sat     <= 1'b0;
    end else begin
      last_en <= bus.rddata_en;
      if (bus.clear) begin
        state <= ST_IDLE;
        cnt   <= '0;
        sat   <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (rise) state <= ST_RUN;
      end else if (GAP_MODE == GAP_MODE_RISE && rise) begin
        cnt <= '0;
        sat <= 1'b0;
      end else if (GAP_MODE == GAP_MODE_FALL && fall) begin
        cnt <= CNT_W'(1);
        sat <= 1'b0;
      end else if (cnt == MAX) begin
        // Holding at MAX one more cycle means the true gap now exceeds MAX.
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       bus.drop_err <= 1'b0;
    else if (bus.clear) bus.drop_err <= 1'b0;
    else if (drop)      bus.drop_err <= 1'b1;
  end

  rd_gap_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.clear),
    .push    (push_req),
    .pop     (bus.gap_ready),
    .din     (push_entry),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (bus.fifo_level)
  );

  assign bus.gap_valid = ~fifo_empty;
  assign bus.gap_count = head[ENTRY_GAP_OFS +: CNT_W];
  assign bus.gap_ovf   = head[OVF_B];
  assign bus.gap_first = head[FIRST_B];
  assign bus.fifo_full = fifo_full;
  assign bus.cnt_busy  = (state == ST_RUN);

`ifdef RD_GAP_STATS_EN
  logic [CNT_W-1:0] gap_min_q;
  logic [CNT_W-1:0] gap_max_q;

  // Tracks every measured entry, including ones the FIFO had to drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_min_q <= MAX;
      gap_max_q <= '0;
    end else if (bus.clear) begin
      gap_min_q <= MAX;
      gap_max_q <= '0;
    end else if (push_req && state == ST_RUN) begin
      if (cnt < gap_min_q) gap_min_q <= cnt;
      if (cnt > gap_max_q) gap_max_q <= cnt;
    end
  end

  assign bus.gap_min = gap_min_q;
  assign bus.gap_max = gap_max_q;
`endif

endmodule

// File: tb/tb_rd_gap_tracker.sv
// Directed bench for rd_gap_tracker: a rise-to-rise instance driven from a vector table,
// plus hand sequences for clear/reset, saturation and the fall-to-rise instance.
module tb_rd_gap_tracker;

  localparam int CNT_W = 5;
  localparam int DEPTH = 4;

  typedef struct {
    logic en;
    logic clr;
    logic rdy;
    logic v;
    int   cnt;
    logic ovf;
    logic fst;
    int   lvl;
    logic full;
    logic drp;
    logic busy;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic en      = 1'b0;
  logic clr     = 1'b0;
  logic rdy     = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rd_gap_tracker_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) if0 ();
  rd_gap_tracker_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) if1 ();

  assign if0.rddata_en = en;
  assign if0.clear     = clr;
  assign if0.gap_ready = rdy;
  assign if1.rddata_en = en;
  assign if1.clear     = clr;
  assign if1.gap_ready = rdy;

  rd_gap_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH), .GAP_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0)
  );
  rd_gap_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH), .GAP_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic r);
    en  = e;
    clr = c;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic v, input int c, input logic o,
                      input logic f, input int l, input logic fu, input logic d,
                      input logic b);
    chk({tag, " valid"}, int'(if0.gap_valid),  int'(v));
    chk({tag, " count"}, int'(if0.gap_count),  c);
    chk({tag, " ovf"},   int'(if0.gap_ovf),    int'(o));
    chk({tag, " first"}, int'(if0.gap_first),  int'(f));
    chk({tag, " level"}, int'(if0.fifo_level), l);
    chk({tag, " full"},  int'(if0.fifo_full),  int'(fu));
    chk({tag, " drop"},  int'(if0.drop_err),   int'(d));
    chk({tag, " busy"},  int'(if0.cnt_busy),   int'(b));
  endtask

  task automatic chk1(input string tag, input logic v, input int c, input logic o,
                      input logic f, input logic b);
    chk({tag, " m1 valid"}, int'(if1.gap_valid), int'(v));
    chk({tag, " m1 count"}, int'(if1.gap_count), c);
    chk({tag, " m1 ovf"},   int'(if1.gap_ovf),   int'(o));
    chk({tag, " m1 first"}, int'(if1.gap_first), int'(f));
    chk({tag, " m1 busy"},  int'(if1.cnt_busy),  int'(b));
  endtask

  function automatic vec_t mk(input logic e, input logic c, input logic r, input logic v,
                              input int cn, input logic o, input logic f, input int l,
                              input logic fu, input logic d, input logic b);
    vec_t x;
    x.en = e;  x.clr = c;  x.rdy = r;  x.v = v;    x.cnt = cn; x.ovf = o;
    x.fst = f; x.lvl = l;  x.full = fu; x.drp = d; x.busy = b;
    return x;
  endfunction

  task automatic add(input vec_t r, input int n);
    repeat (n) tbl.push_back(r);
  endtask

  task automatic rise_after(input int n);
    repeat (n - 1) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    //        en c  r   v  cnt o  f  lvl fu d  b
    add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    add(mk(1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1), 1);
    add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 3);
    add(mk(1, 0, 1, 1, 3, 0, 0, 1, 0, 0, 1), 1);
    add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 5);
    add(mk(1, 0, 1, 1, 5, 0, 0, 1, 0, 0, 1), 1);
    add(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 2);
    add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    add(mk(1, 0, 1, 1, 3, 0, 0, 1, 0, 0, 1), 1);
    add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1);
    // fill with the consumer stalled, then overflow the FIFO
    add(mk(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1), 1);
    add(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1), 2);
    add(mk(1, 0, 0, 1, 1, 0, 0, 2, 0, 0, 1), 1);
    add(mk(0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 1), 3);
    add(mk(1, 0, 0, 1, 1, 0, 0, 3, 0, 0, 1), 1);
    add(mk(0, 0, 0, 1, 1, 0, 0, 3, 0, 0, 1), 4);
    add(mk(1, 0, 0, 1, 1, 0, 0, 4, 1, 0, 1), 1);
    add(mk(0, 0, 0, 1, 1, 0, 0, 4, 1, 0, 1), 1);
    add(mk(1, 0, 0, 1, 1, 0, 0, 4, 1, 1, 1), 1);
    add(mk(0, 0, 1, 1, 2, 0, 0, 3, 0, 1, 1), 1);
    add(mk(0, 0, 1, 1, 3, 0, 0, 2, 0, 1, 1), 1);
    add(mk(0, 0, 1, 1, 4, 0, 0, 1, 0, 1, 1), 1);
    add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1), 1);
    add(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    // refill to full, then push and pop in the same cycle
    add(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1), 1);
    add(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1), 1);
    add(mk(1, 0, 0, 1, 0, 0, 1, 2, 0, 0, 1), 1);
    add(mk(0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 1), 2);
    add(mk(1, 0, 0, 1, 0, 0, 1, 3, 0, 0, 1), 1);
    add(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 0, 1), 3);
    add(mk(1, 0, 0, 1, 0, 0, 1, 4, 1, 0, 1), 1);
    add(mk(0, 0, 0, 1, 0, 0, 1, 4, 1, 0, 1), 1);
    add(mk(1, 0, 1, 1, 1, 0, 0, 4, 1, 0, 1), 1);
    add(mk(0, 0, 1, 1, 2, 0, 0, 3, 0, 0, 1), 1);
    add(mk(0, 0, 1, 1, 3, 0, 0, 2, 0, 0, 1), 1);
    add(mk(0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1), 1);
    add(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].rdy);
      chk0($sformatf("row%0d", i), tbl[i].v, tbl[i].cnt, tbl[i].ovf, tbl[i].fst,
           tbl[i].lvl, tbl[i].full, tbl[i].drp, tbl[i].busy);
    end

    // clear in the same cycle as a rise, two entries queued
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("pre_clear level", int'(if0.fifo_level), 2);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk0("clr_rise", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 0);
    chk("held_high valid", int'(if0.gap_valid), 0);
    chk("held_high busy", int'(if0.cnt_busy), 0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    chk0("after_clr", 1, 0, 0, 1, 1, 0, 0, 1);

    // reset pulsed mid-gap with two entries queued
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("pre_reset level", int'(if0.fifo_level), 2);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    chk0("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    chk0("after_rst", 1, 0, 0, 1, 1, 0, 0, 1);

    // saturation boundaries, rise-to-rise
    rise_after(40);
    chk0("gap39", 1, 31, 1, 0, 1, 0, 0, 1);
    rise_after(32);
    chk0("gap31", 1, 31, 0, 0, 1, 0, 0, 1);
    rise_after(33);
    chk0("gap32", 1, 31, 1, 0, 1, 0, 0, 1);
    rise_after(31);
    chk0("gap30", 1, 30, 0, 0, 1, 0, 0, 1);

    // fall-to-rise instance
    drive(1'b0, 1'b1, 1'b1);
    chk1("m1_clr", 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b1);
    chk1("m1_first", 1, 0, 0, 1, 1);
    repeat (3) drive(1'b1, 1'b0, 1'b1);
    repeat (7) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk1("m1_low7", 1, 7, 0, 0, 1);
    repeat (31) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk1("m1_low31", 1, 31, 0, 0, 1);
    repeat (32) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk1("m1_low32", 1, 31, 1, 0, 1);
    drive(1'b0, 1'b0, 1'b1);
    chk1("m1_drain", 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
